// File: rtl/sw_reg_wb_master_pkg.sv
// Shared types and constants for the sw_reg Wishbone initiator.
package sw_reg_pkg;

    localparam int C_WB_ADR_W        = 32;
    localparam int C_WB_DAT_W        = 32;
    localparam int C_WB_SEL_W        = 4;
    localparam int C_DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] adr_lsb);
        return adr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/sw_reg_wb_master_if.sv
// Command/response fabric port and Wishbone classic bus of the sw_reg initiator.
interface sw_reg_wb_master_if;
    import sw_reg_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [C_WB_SEL_W-1:0] cmd_sel;
    logic [C_WB_ADR_W-1:0] cmd_adr;
    logic [C_WB_DAT_W-1:0] cmd_dat;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [C_WB_DAT_W-1:0] rsp_dat;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  busy;

    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [C_WB_SEL_W-1:0] wb_sel_o;
    logic [C_WB_ADR_W-1:0] wb_adr_o;
    logic [C_WB_DAT_W-1:0] wb_dat_o;
    logic [C_WB_DAT_W-1:0] wb_dat_i;
    logic                  wb_ack_i;
    logic                  wb_err_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready,
        input  wb_dat_i, wb_ack_i, wb_err_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err, rsp_timeout, busy,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready,
        output wb_dat_i, wb_ack_i, wb_err_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err, rsp_timeout, busy,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
    );

endinterface

// File: rtl/sw_reg_wb_timeout.sv
// 16-bit bus-cycle watchdog; tc_o flags the last allowed cycle when enabled.
module sw_reg_wb_timeout
    import sw_reg_pkg::*;
#(
    parameter int C_TIMEOUT = C_DEFAULT_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [15:0] C_TC_VAL = (C_TIMEOUT == 0) ? 16'd0 : 16'(C_TIMEOUT - 1);

    logic [15:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign tc_o = (C_TIMEOUT != 0) && (cnt_q == C_TC_VAL);

endmodule

// File: rtl/sw_reg_wb_master.sv
// Single-outstanding Wishbone classic initiator: one command in, one bus cycle, one response out.
module sw_reg_wb_master
    import sw_reg_pkg::*;
#(
    parameter int C_TIMEOUT     = C_DEFAULT_TIMEOUT,
    parameter bit C_ALIGN_CHECK = 1'b1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    sw_reg_wb_master_if.master bus
);

    state_e                state_q;
    logic                  busy_q;
    logic                  cyc_q;
    logic                  stb_q;
    logic                  we_q;
    logic [C_WB_SEL_W-1:0] sel_q;
    logic [C_WB_ADR_W-1:0] adr_q;
    logic [C_WB_DAT_W-1:0] dat_q;
    logic                  rsp_valid_q;
    logic [C_WB_DAT_W-1:0] rsp_dat_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;
    logic                  tc;
    logic                  term;

    sw_reg_wb_timeout #(
        .C_TIMEOUT (C_TIMEOUT)
    ) u_timeout (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .clr_i (state_q != ST_BUS),
        .en_i  (state_q == ST_BUS),
        .tc_o  (tc)
    );

    assign term = bus.wb_err_i || bus.wb_ack_i || tc;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            sel_q         <= '0;
            adr_q         <= '0;
            dat_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_dat_q     <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        sel_q  <= bus.cmd_sel;
                        adr_q  <= bus.cmd_adr;
                        dat_q  <= bus.cmd_dat;
                        busy_q <= 1'b1;
                        if (C_ALIGN_CHECK && is_misaligned(bus.cmd_adr[1:0])) begin
                            state_q       <= ST_RESP;
                            rsp_valid_q   <= 1'b1;
                            rsp_err_q     <= 1'b1;
                            rsp_timeout_q <= 1'b0;
                            rsp_dat_q     <= '0;
                        end else begin
                            state_q <= ST_BUS;
                            we_q    <= bus.cmd_we;
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                        end
                    end
                end
                ST_BUS: begin
                    if (term) begin
                        // err beats ack; neither means the watchdog fired
                        state_q       <= ST_RESP;
                        cyc_q         <= 1'b0;
                        stb_q         <= 1'b0;
                        we_q          <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= bus.wb_err_i || !bus.wb_ack_i;
                        rsp_timeout_q <= !bus.wb_err_i && !bus.wb_ack_i;
                        rsp_dat_q     <= (!bus.wb_err_i && bus.wb_ack_i && !we_q) ? bus.wb_dat_i : '0;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = (state_q == ST_IDLE) && !wb_rst_i;
    assign bus.busy        = busy_q;
    assign bus.wb_cyc_o    = cyc_q;
    assign bus.wb_stb_o    = stb_q;
    assign bus.wb_we_o     = we_q;
    assign bus.wb_sel_o    = sel_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_dat_o    = dat_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_dat     = rsp_dat_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_sw_reg_wb_master.sv
// Directed bench for sw_reg_wb_master against a small wait-state Wishbone slave.
module tb_sw_reg_wb_master;
    import sw_reg_pkg::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sw_reg_wb_master_if bus ();

    sw_reg_wb_master #(
        .C_TIMEOUT     (TO),
        .C_ALIGN_CHECK (1'b1)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // slave: ack/err after slv_wait wait states, returns slv_rdata
    int          slv_wait   = 0;
    bit          slv_ack_en = 1'b1;
    bit          slv_err_en = 1'b0;
    logic [31:0] slv_rdata  = 32'h0;
    int          slv_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst)                             slv_cnt <= 0;
        else if (bus.wb_cyc_o && bus.wb_stb_o) slv_cnt <= slv_cnt + 1;
        else                                 slv_cnt <= 0;
    end

    assign bus.wb_ack_i = slv_ack_en && bus.wb_cyc_o && bus.wb_stb_o && (slv_cnt == slv_wait);
    assign bus.wb_err_i = slv_err_en && bus.wb_cyc_o && bus.wb_stb_o && (slv_cnt == slv_wait);
    assign bus.wb_dat_i = slv_rdata;

    task automatic send_cmd(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                            input logic [31:0] dat, output bit accepted);
        accepted = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_sel = sel;
            bus.cmd_adr = adr; bus.cmd_dat = dat;
            if (bus.cmd_ready) begin
                @(posedge clk);
                #1 bus.cmd_valid = 1'b0;
                accepted = 1'b1;
                break;
            end
        end
        $display("cmd: we=%b adr=%h dat=%h accepted=%b", we, adr, dat, accepted);
    endtask

    task automatic wait_rsp(output int n_neg, output int cyc_cycles, output bit ok,
                            output logic [31:0] first_dat_o, output logic [31:0] first_adr_o);
        n_neg = 0; cyc_cycles = 0; ok = 1'b0; first_dat_o = 'x; first_adr_o = 'x;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n_neg++;
            if (bus.rsp_valid) begin ok = 1'b1; break; end
            if (bus.wb_cyc_o) begin
                if (cyc_cycles == 0) begin first_dat_o = bus.wb_dat_o; first_adr_o = bus.wb_adr_o; end
                cyc_cycles++;
            end
        end
    endtask

    task automatic take_rsp();
        $display("rsp: dat=%h err=%b timeout=%b", bus.rsp_dat, bus.rsp_err, bus.rsp_timeout);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (bus.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_ready: got %b expected 0", bus.cmd_ready); end
        vectors++; if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0) begin miscompares++; $display("FAIL reset_cyc_stb: got %b%b expected 00", bus.wb_cyc_o, bus.wb_stb_o); end
        vectors++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_busy: got %b%b expected 00", bus.rsp_valid, bus.busy); end
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b expected 1", bus.cmd_ready); end
    endtask

    task automatic test_write();
        bit acc, ok; int n, cc; logic [31:0] d0, a0;
        slv_wait = 0;
        send_cmd(1'b1, 4'hF, 32'h0000_0000, 32'hEEEE_EEEE, acc);
        wait_rsp(n, cc, ok, d0, a0);
        vectors++; if (!(acc && ok)) begin miscompares++; $display("FAIL write_handshake: got acc=%b rsp=%b expected 1 1", acc, ok); end
        vectors++; if (cc !== 1) begin miscompares++; $display("FAIL write_cyc_len: got %0d expected 1", cc); end
        vectors++; if (d0 !== 32'hEEEE_EEEE) begin miscompares++; $display("FAIL write_dat_o: got %h expected eeeeeeee", d0); end
        vectors++; if (bus.rsp_err !== 1'b0 || bus.rsp_dat !== 32'h0) begin miscompares++; $display("FAIL write_rsp: got err=%b dat=%h expected err=0 dat=0", bus.rsp_err, bus.rsp_dat); end
        take_rsp();
    endtask

    task automatic test_read();
        bit acc, ok; int n, cc; logic [31:0] d0, a0;
        slv_wait = 3; slv_rdata = 32'h1234_5678;
        send_cmd(1'b0, 4'hF, 32'h0000_0004, 32'h0, acc);
        wait_rsp(n, cc, ok, d0, a0);
        vectors++; if (!(acc && ok)) begin miscompares++; $display("FAIL read_handshake: got acc=%b rsp=%b expected 1 1", acc, ok); end
        vectors++; if (cc !== 4) begin miscompares++; $display("FAIL read_cyc_len: got %0d expected 4", cc); end
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL read_latency: got %0d expected 5", n); end
        vectors++; if (a0 !== 32'h0000_0004) begin miscompares++; $display("FAIL read_adr_o: got %h expected 00000004", a0); end
        vectors++; if (bus.rsp_dat !== 32'h1234_5678 || bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL read_rsp: got dat=%h err=%b expected 12345678 0", bus.rsp_dat, bus.rsp_err); end
        take_rsp();
    endtask

    task automatic test_timeout();
        bit acc, ok; int n, cc; logic [31:0] d0, a0;
        slv_ack_en = 1'b0; slv_wait = 0; slv_rdata = 32'hDEAD_BEEF;
        send_cmd(1'b0, 4'hF, 32'h0000_0008, 32'h0, acc);
        wait_rsp(n, cc, ok, d0, a0);
        vectors++; if (!(acc && ok)) begin miscompares++; $display("FAIL timeout_handshake: got acc=%b rsp=%b expected 1 1", acc, ok); end
        vectors++; if (cc !== TO) begin miscompares++; $display("FAIL timeout_cyc_len: got %0d expected %0d", cc, TO); end
        vectors++; if (bus.rsp_err !== 1'b1 || bus.rsp_timeout !== 1'b1 || bus.rsp_dat !== 32'h0) begin miscompares++; $display("FAIL timeout_rsp: got err=%b to=%b dat=%h expected 1 1 0", bus.rsp_err, bus.rsp_timeout, bus.rsp_dat); end
        take_rsp();
        slv_ack_en = 1'b1;
        send_cmd(1'b1, 4'h3, 32'h0000_000C, 32'h0000_5555, acc);
        wait_rsp(n, cc, ok, d0, a0);
        vectors++; if (!(acc && ok) || cc !== 1) begin miscompares++; $display("FAIL timeout_next_cmd: got acc=%b rsp=%b cyc=%0d expected 1 1 1", acc, ok, cc); end
        vectors++; if (bus.rsp_err !== 1'b0 || bus.rsp_timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_next_rsp: got err=%b to=%b expected 0 0", bus.rsp_err, bus.rsp_timeout); end
        take_rsp();
    endtask

    task automatic test_errors();
        bit acc, ok; int n, cc; logic [31:0] d0, a0;
        slv_wait = 1; slv_err_en = 1'b1; slv_rdata = 32'hCAFE_F00D;
        send_cmd(1'b0, 4'hF, 32'h0000_0010, 32'h0, acc);
        wait_rsp(n, cc, ok, d0, a0);
        slv_err_en = 1'b0;
        vectors++; if (!(acc && ok) || cc !== 2) begin miscompares++; $display("FAIL ackerr_cycle: got acc=%b rsp=%b cyc=%0d expected 1 1 2", acc, ok, cc); end
        vectors++; if (bus.rsp_err !== 1'b1 || bus.rsp_timeout !== 1'b0 || bus.rsp_dat !== 32'h0) begin miscompares++; $display("FAIL ackerr_rsp: got err=%b to=%b dat=%h expected 1 0 0", bus.rsp_err, bus.rsp_timeout, bus.rsp_dat); end
        take_rsp();
        slv_wait = 0;
        send_cmd(1'b1, 4'hF, 32'h0000_0002, 32'h1111_1111, acc);
        wait_rsp(n, cc, ok, d0, a0);
        vectors++; if (!(acc && ok) || n !== 1) begin miscompares++; $display("FAIL misalign_latency: got acc=%b rsp=%b n=%0d expected 1 1 1", acc, ok, n); end
        vectors++; if (cc !== 0 || bus.wb_cyc_o !== 1'b0) begin miscompares++; $display("FAIL misalign_no_cyc: got cyc_cycles=%0d cyc=%b expected 0 0", cc, bus.wb_cyc_o); end
        vectors++; if (bus.rsp_err !== 1'b1 || bus.rsp_timeout !== 1'b0 || bus.rsp_dat !== 32'h0) begin miscompares++; $display("FAIL misalign_rsp: got err=%b to=%b dat=%h expected 1 0 0", bus.rsp_err, bus.rsp_timeout, bus.rsp_dat); end
        take_rsp();
    endtask

    task automatic test_backpressure();
        bit acc, ok; int n, cc; logic [31:0] d0, a0;
        slv_wait = 0; slv_rdata = 32'hA5A5_A5A5;
        send_cmd(1'b0, 4'hF, 32'h0000_0008, 32'h0, acc);
        wait_rsp(n, cc, ok, d0, a0);
        vectors++; if (!(acc && ok)) begin miscompares++; $display("FAIL bp_handshake: got acc=%b rsp=%b expected 1 1", acc, ok); end
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_sel = 4'hF;
        bus.cmd_adr = 32'h0000_0010; bus.cmd_dat = 32'h1111_2222;
        for (int i = 0; i < 5; i++) begin
            vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== 32'hA5A5_A5A5 || bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL bp_hold[%0d]: got v=%b dat=%h err=%b expected 1 a5a5a5a5 0", i, bus.rsp_valid, bus.rsp_dat, bus.rsp_err); end
            vectors++; if (bus.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL bp_cmd_ready[%0d]: got %b expected 0", i, bus.cmd_ready); end
            @(negedge clk);
        end
        take_rsp();
        vectors++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got v=%b ready=%b expected 0 1", bus.rsp_valid, bus.cmd_ready); end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        vectors++; if (bus.wb_cyc_o !== 1'b1 || bus.wb_we_o !== 1'b1 || bus.wb_dat_o !== 32'h1111_2222) begin miscompares++; $display("FAIL bp_next_accept: got cyc=%b we=%b dat=%h expected 1 1 11112222", bus.wb_cyc_o, bus.wb_we_o, bus.wb_dat_o); end
        wait_rsp(n, cc, ok, d0, a0);
        vectors++; if (!ok || bus.rsp_err !== 1'b0 || bus.rsp_dat !== 32'h0) begin miscompares++; $display("FAIL bp_next_rsp: got v=%b err=%b dat=%h expected 1 0 0", ok, bus.rsp_err, bus.rsp_dat); end
        take_rsp();
    endtask

    task automatic test_reset_mid();
        bit acc;
        slv_ack_en = 1'b0;
        send_cmd(1'b0, 4'hF, 32'h0000_0020, 32'h0, acc);
        @(negedge clk);
        vectors++; if (!acc || bus.wb_cyc_o !== 1'b1 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_bus: got acc=%b cyc=%b busy=%b expected 1 1 1", acc, bus.wb_cyc_o, bus.busy); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_async_drop: got cyc=%b stb=%b busy=%b expected 0 0 0", bus.wb_cyc_o, bus.wb_stb_o, bus.busy); end
        vectors++; if (bus.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready_low: got %b expected 0", bus.cmd_ready); end
        @(negedge clk);
        rst = 1'b0;
        slv_ack_en = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.wb_cyc_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_after: got ready=%b v=%b cyc=%b expected 1 0 0", bus.cmd_ready, bus.rsp_valid, bus.wb_cyc_o); end
        repeat (3) @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_rsp: got %b expected 0", bus.rsp_valid); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_sel = 4'h0;
        bus.cmd_adr = 32'h0; bus.cmd_dat = 32'h0; bus.rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sw_reg_wb_master.md
Name: sw_reg_wb_master

Overview:
- Single-outstanding Wishbone classic initiator that drives the sw_reg family of slaves, such as readable and writable software registers.
- Accepts one read or write command on a valid/ready fabric port.
- Runs one Wishbone cycle per command and returns read data plus status on a valid/ready response port.
- Used by fabric-side controllers and by regression benches to reach register slaves without a processor.

Parameters:
- C_TIMEOUT, 255: cycles to wait in a bus cycle for ack/err before aborting. 0 disables the timeout. Legal range is 0..65535.
- C_ALIGN_CHECK, 1: when 1, a command with adr[1:0]≠0 is rejected with an error and no bus cycle is run.

Ports:
- wb_clk_i  in  1  sole clock; every interface is synchronous to it
- wb_rst_i  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts command
- cmd_we  in  1  1 = write, 0 = read
- cmd_sel  in  4  byte selects
- cmd_adr  in  32  byte address
- cmd_dat  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_dat  out  32  read data (0 for writes and failures)
- rsp_err  out  1  slave err, timeout, or misaligned
- rsp_timeout  out  1  failure was a timeout
- busy  out  1  high whenever state≠IDLE
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_sel_o  out  4  Wishbone byte selects
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge
- wb_err_i  in  1  Wishbone error

Behaviour:
- Reset: asynchronous, active-high.
  - All outputs are 0 while wb_rst_i=1; cmd_ready is 0 during reset.
  - State goes to IDLE and the timeout counter to 0.
  - Reset mid-cycle drops cyc/stb immediately; any pending response is discarded.
- All outputs are registered except cmd_ready, which equals (state==IDLE).
- States: IDLE, BUS, RESP.
- IDLE:
  - A handshake (cmd_valid & cmd_ready) at edge N latches we/sel/adr/dat.
  - Normal case: go to BUS; wb_cyc_o = wb_stb_o = 1 from edge N, with latched fields on wb_*_o.
  - Misaligned address with C_ALIGN_CHECK=1: go straight to RESP with rsp_err=1, rsp_timeout=0, rsp_dat=0. No cyc is asserted.
- BUS: sample each edge.
  - wb_err_i=1 (including simultaneous ack and err; err wins): terminate with rsp_err=1.
  - else wb_ack_i=1: terminate with rsp_err=0. For reads, rsp_dat = wb_dat_i sampled at that edge; for writes, rsp_dat = 0.
  - else, if C_TIMEOUT≠0 and the counter equals C_TIMEOUT-1: terminate with rsp_err=1, rsp_timeout=1, rsp_dat=0.
  - otherwise the counter increments.
  - Termination at edge M: cyc/stb/we deassert at M, rsp_valid rises at M, and the state goes to RESP.
  - A slave acking in the first BUS cycle gives a minimum bus occupancy of 1 cycle.
  - adr/sel/dat hold stable for the whole cycle.
- RESP:
  - rsp_* hold stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: rsp_valid clears at that edge, the state goes to IDLE, and the counter is cleared.
  - cmd_ready rises the cycle after the response is taken (no same-cycle new command).
- Latency, command accept to rsp_valid: 1 + (slave ack delay) cycles. Back-to-back commands have ≥1 idle cycle with cyc=0 between them.
- Acks arriving in IDLE or RESP are ignored; they are never counted.
- Counter is 16 bits and saturates are unreachable by the parameter range.

Decomposition:
- Shared package sw_reg_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_BUS=2'd1, ST_RESP=2'd2
  - C_WB_ADR_W=32, C_WB_DAT_W=32, C_WB_SEL_W=4
  - the default timeout constant
- One sub-module, sw_reg_wb_timeout, is the 16-bit clear/enable counter with a terminal-count output compared against C_TIMEOUT.
- Everything else, the FSM and datapath registers, lives in the top.

Test Plan:
1. Write to a sw_reg-style slave (ack 1 cycle after stb):
   - Stimulus: cmd_we=1, adr=0x00000000, sel=0xF, dat=0xEEEEEEEE.
   - Response: cyc/stb high exactly 1 cycle with wb_dat_o=0xEEEEEEEE; rsp_valid with rsp_err=0, rsp_dat=0.
2. Read from a sw_reg_r-style slave:
   - Stimulus: cmd_we=0, adr=0x00000004; the slave returns 0x12345678 with ack after 3 cycles.
   - Response: rsp_dat=0x12345678, rsp_err=0; cyc high 4 cycles.
3. Timeout:
   - Stimulus: C_TIMEOUT=8, no ack.
   - Response: cyc high exactly 8 cycles; then rsp_err=1, rsp_timeout=1, rsp_dat=0; the next command is accepted normally.
4. Error cases:
   - Simultaneous wb_ack_i=1 and wb_err_i=1 → rsp_err=1, rsp_timeout=0.
   - Misaligned adr=0x00000002 → no cyc ever asserted, rsp_err=1 on the edge after accept.
5. Response backpressure:
   - Stimulus: rsp_ready held 0 for 5 cycles after a read returning 0xA5A5A5A5; a new cmd_valid is held high.
   - Response: rsp fields stable; cmd_ready=0 throughout; command accepted the cycle after rsp_ready=1.
6. Reset mid-cycle:
   - Stimulus: assert wb_rst_i asynchronously (between edges) during BUS.
   - Response: wb_cyc_o/wb_stb_o/busy go 0 without waiting for an edge; no rsp_valid after release; cmd_ready=1 on the first edge after release.
